line_buf_sched: RTL and testbench
=================================

// Module: line_buf_sched
// PURPOSE
//  Scheduler that sequences the three RAM-backed FIFOs as rotating line buffers.
//  It turns a raster pixel stream into 3-row pixel columns for the 3x3 window datapath.
//  It sits between the pixel source and the three fifo instances, and drives all fifo enables and data.
//  Its column output feeds the window/kernel stage.
// PARAMETERS
//  DATA_WIDTH  32  pixel width, equal to the fifo data width
//  DIM_WIDTH   8   width of the width/height fields and of the row/column counters
// PORTS
//  clk             in   1             clock
//  rstn            in   1             asynchronous active-low reset
//  start_op        in   1             1-cycle frame start pulse
//  width           in   DIM_WIDTH     pixels per row; latched at start
//  height          in   DIM_WIDTH     rows per frame; latched at start
//  in_valid        in   1             in_pixel valid
//  in_pixel        in   DATA_WIDTH    raster pixel
//  in_ready        out  1             pixel accepted when in_valid & in_ready
//  fifo_full_i     in   3             bit k = fifo k full
//  fifo_empty_i    in   3             bit k = fifo k empty
//  fifo_data_out_i in   3*DATA_WIDTH  {f2,f1,f0} read data, valid 1 cycle after rd_en
//  fifo_data_in_o  out  3*DATA_WIDTH  {f2,f1,f0} write data
//  fifo_wr_en_o    out  3             write enable; also drives fifoN_wr_cs
//  fifo_rd_en_o    out  3             read enable; also drives fifoN_rd_cs
//  col_valid       out  1             col_data valid, 1-cycle qualifier, no backpressure
//  col_data        out  3*DATA_WIDTH  {row r-2, row r-1, row r} at the same column
//  busy            out  1             high outside IDLE
//  done            out  1             1-cycle pulse at frame end
//  cfg_err         out  1             1-cycle pulse with done when the latched config is illegal
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame abandons the frame; the fifos share rstn.
//  - Row r is written into fifo (r mod 3). In STREAM, for row r:
//    - W = fifo (r mod 3) is written with in_pixel.
//    - O = fifo ((r+1) mod 3) is read and its data discarded after use (row r-2).
//    - M = fifo ((r+2) mod 3) is read and each word is rewritten into M one cycle later (row r-1 recirculates).
//  - Accept cycle t: wr_en[W]=1 with data in_pixel. In STREAM, also rd_en[O]=rd_en[M]=1.
//  - Cycle t+1:
//    - col_valid=1.
//    - col_data={O_out, M_out, registered in_pixel}.
//    - wr_en[M]=1 with data M_out.
//  - Latency from accepted pixel to col_valid: 1 cycle.
//  - in_ready:
//    - FILL: !full[W].
//    - STREAM: !full[W] & !full[M] & !empty[O] & !empty[M].
//    - 0 in all other states.
//  - Column counter runs 0..width-1 and wraps to 0 at the end of a row, which advances the row counter.
//  - FSM:
//    - IDLE -> FILL on start_op. Latch width/height.
//    - If height<3 or width==0: go to DONE instead, with cfg_err asserted.
//    - FILL: rows 0 and 1, write only, no col_valid -> STREAM after the last pixel of row 1.
//    - STREAM: rows 2..height-1 -> FLUSH after the last pixel of row height-1.
//    - FLUSH: 1 cycle so the final recirculated write lands -> DRAIN.
//    - DRAIN: rd_en on every non-empty fifo each cycle, outputs suppressed -> DONE when all three are empty.
//    - DONE: done=1 for 1 cycle -> IDLE.
//  - start_op outside IDLE is ignored.
//  - A frame produces exactly (height-2)*width col_valid beats.
//  - Fifo depth must be >= width+1, because M holds a full row plus one word in flight.
// CONFIGURATION
//  - LBS_EDGE_FLAG_EN defined:
//    - Adds outputs col_first and col_last (1 bit each).
//    - They are aligned with col_valid and mark column 0 and column width-1 of each output row.
//    - Both reset to 0.
//  - LBS_EDGE_FLAG_EN undefined: these ports and their logic are absent; all other behaviour is identical.
// TESTING
//  1. width=4, height=3, in_valid held 1, pixels 1..12.
//     -> 4 col_valid beats {1,5,9},{2,6,10},{3,7,11},{4,8,12}; done 1 cycle after all fifos are empty.
//  2. width=3, height=5, pixels 1..15.
//     -> 9 beats; beat 4 = {4,7,10}, beat 9 = {9,12,15}.
//     -> fifo_empty_i=3'b111 at done.
//  3. in_valid toggled randomly and fifo1 held full for 5 cycles in STREAM.
//     -> in_ready=0 for those cycles; no pixel lost or duplicated; output identical to the no-stall run.
//  4. start_op with height=2 -> done and cfg_err in the same cycle, no fifo enable asserted.
//     start_op during STREAM -> ignored.
//  5. rstn low mid-STREAM.
//     -> outputs 0 at once, state IDLE; a following frame with width=4, height=3 matches scenario 1.
//  6. LBS_EDGE_FLAG_EN build, scenario 1 stimulus -> col_first on beat 1 only, col_last on beat 4 only.

Source files
------------

// File: rtl/line_buf_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : line_buf_sched                                             |
// | Description : Sequences three RAM-backed FIFOs as rotating line buffers  |
// |               and turns a raster pixel stream into 3-row pixel columns   |
// |               for the 3x3 window datapath.                               |
// |               Optional macro LBS_EDGE_FLAG_EN adds col_first/col_last.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module line_buf_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_op,
  input  logic [DIM_WIDTH-1:0]    width,
  input  logic [DIM_WIDTH-1:0]    height,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  output logic                    in_ready,
  input  logic [2:0]              fifo_full_i,
  input  logic [2:0]              fifo_empty_i,
  input  logic [3*DATA_WIDTH-1:0] fifo_data_out_i,
  output logic [3*DATA_WIDTH-1:0] fifo_data_in_o,
  output logic [2:0]              fifo_wr_en_o,
  output logic [2:0]              fifo_rd_en_o,
  output logic                    col_valid,
  output logic [3*DATA_WIDTH-1:0] col_data,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
`ifdef LBS_EDGE_FLAG_EN
  ,
  output logic                    col_first,
  output logic                    col_last
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Modulo-3 increment of a fifo index
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] x);
    return 3'b001 << x;
  endfunction

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  width_q, width_d;
  logic [DIM_WIDTH-1:0]  height_q, height_d;
  logic [DIM_WIDTH-1:0]  col_q, col_d;
  logic [DIM_WIDTH-1:0]  row_q, row_d;
  logic [1:0]            w_idx_q, w_idx_d;   // fifo receiving the current row
  logic [1:0]            o_sel_q, o_sel_d;   // oldest-row fifo of the beat in flight
  logic [1:0]            m_sel_q, m_sel_d;   // middle-row fifo of the beat in flight
  logic [2:0]            wb_q, wb_d;         // one-hot recirculation write-back
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic                  col_valid_q, col_valid_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;
`ifdef LBS_EDGE_FLAG_EN
  logic                  first_q, first_d;
  logic                  last_q, last_d;
`endif

  logic [1:0]            o_idx;
  logic [1:0]            m_idx;
  logic                  accept;
  logic                  last_col;
  logic [DATA_WIDTH-1:0] fout [3];

  assign last_col = (col_q == width_q - DIM_WIDTH'(1));

  // Per-fifo read-data unpacking and write-data selection (recirculation wins
  // only on its own fifo, which is never the fifo taking the new pixel)
  generate
    for (genvar k = 0; k < 3; k++) begin : g_fifo
      assign fout[k] = fifo_data_out_i[k*DATA_WIDTH +: DATA_WIDTH];
      assign fifo_data_in_o[k*DATA_WIDTH +: DATA_WIDTH] =
        wb_q[k]                        ? fout[k]  :
        (accept && w_idx_q == 2'(k))   ? in_pixel : '0;
    end
  endgenerate

  // Handshake and fifo enables from the current state and fifo flags
  always_comb begin
    o_idx    = inc3(w_idx_q);
    m_idx    = inc3(o_idx);
    in_ready = 1'b0;
    case (state_q)
      S_FILL:   in_ready = !fifo_full_i[w_idx_q];
      S_STREAM: in_ready = !fifo_full_i[w_idx_q] && !fifo_full_i[m_idx] &&
                           !fifo_empty_i[o_idx] && !fifo_empty_i[m_idx];
      default:  in_ready = 1'b0;
    endcase
    accept       = in_valid && in_ready;
    fifo_wr_en_o = wb_q | (accept ? onehot3(w_idx_q) : 3'b000);
    fifo_rd_en_o = 3'b000;
    if (state_q == S_STREAM && accept)
      fifo_rd_en_o = onehot3(o_idx) | onehot3(m_idx);
    else if (state_q == S_DRAIN)
      fifo_rd_en_o = ~fifo_empty_i;
  end

  // Next-state logic: frame sequencing, row/column counting, beat pipeline
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    col_d       = col_q;
    row_d       = row_q;
    w_idx_d     = w_idx_q;
    o_sel_d     = o_sel_q;
    m_sel_d     = m_sel_q;
    pix_d       = pix_q;
    wb_d        = 3'b000;
    col_valid_d = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
`ifdef LBS_EDGE_FLAG_EN
    first_d     = 1'b0;
    last_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_op) begin
          width_d  = width;
          height_d = height;
          col_d    = '0;
          row_d    = '0;
          w_idx_d  = 2'd0;
          if (height < DIM_WIDTH'(3) || width == '0) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cfg_err_d = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL, S_STREAM: begin
        if (accept) begin
          pix_d = in_pixel;
          if (state_q == S_STREAM) begin
            col_valid_d = 1'b1;
            wb_d        = onehot3(m_idx);
            o_sel_d     = o_idx;
            m_sel_d     = m_idx;
`ifdef LBS_EDGE_FLAG_EN
            first_d     = (col_q == '0);
            last_d      = last_col;
`endif
          end
          if (last_col) begin
            col_d   = '0;
            row_d   = row_q + DIM_WIDTH'(1);
            w_idx_d = inc3(w_idx_q);
            if (state_q == S_FILL && row_q == DIM_WIDTH'(1))
              state_d = S_STREAM;
            if (state_q == S_STREAM && row_q == height_q - DIM_WIDTH'(1))
              state_d = S_FLUSH;
          end else begin
            col_d = col_q + DIM_WIDTH'(1);
          end
        end
      end
      S_FLUSH: state_d = S_DRAIN;
      S_DRAIN: begin
        if (fifo_empty_i == 3'b111) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      w_idx_q     <= 2'd0;
      o_sel_q     <= 2'd0;
      m_sel_q     <= 2'd0;
      pix_q       <= '0;
      wb_q        <= 3'b000;
      col_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef LBS_EDGE_FLAG_EN
      first_q     <= 1'b0;
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      w_idx_q     <= w_idx_d;
      o_sel_q     <= o_sel_d;
      m_sel_q     <= m_sel_d;
      pix_q       <= pix_d;
      wb_q        <= wb_d;
      col_valid_q <= col_valid_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
`ifdef LBS_EDGE_FLAG_EN
      first_q     <= first_d;
      last_q      <= last_d;
`endif
    end
  end

  assign col_valid = col_valid_q;
  assign col_data  = col_valid_q ? {fout[o_sel_q], fout[m_sel_q], pix_q} : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
`ifdef LBS_EDGE_FLAG_EN
  assign col_first = first_q;
  assign col_last  = last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_buf_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_line_buf_sched                                          |
// | Description : Scoreboard bench for line_buf_sched with three behavioural |
// |               FIFOs; expected columns come from the frame image.         |
// |               Honours LBS_EDGE_FLAG_EN for col_first/col_last.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_line_buf_sched;
  localparam int DW    = 32;
  localparam int DIMW  = 8;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start_op = 1'b0;
  logic [DIMW-1:0] width = '0;
  logic [DIMW-1:0] height = '0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_pixel = '0;
  logic            in_ready;
  logic [2:0]      fifo_full_i;
  logic [2:0]      fifo_empty_i;
  logic [3*DW-1:0] fifo_data_out_i;
  logic [3*DW-1:0] fifo_data_in_o;
  logic [2:0]      fifo_wr_en_o;
  logic [2:0]      fifo_rd_en_o;
  logic            col_valid;
  logic [3*DW-1:0] col_data;
  logic            busy, done, cfg_err;
`ifdef LBS_EDGE_FLAG_EN
  logic            col_first, col_last;
`endif

  line_buf_sched #(.DATA_WIDTH(DW), .DIM_WIDTH(DIMW)) dut (
    .clk(clk), .rstn(rstn), .start_op(start_op), .width(width), .height(height),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
    .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .fifo_data_out_i(fifo_data_out_i), .fifo_data_in_o(fifo_data_in_o),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_rd_en_o(fifo_rd_en_o),
    .col_valid(col_valid), .col_data(col_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef LBS_EDGE_FLAG_EN
    , .col_first(col_first), .col_last(col_last)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural FIFOs (1-cycle read latency) ----------------
  logic [DW-1:0] fmem [3][DEPTH];
  int            fcnt [3];
  int            frp  [3];
  int            fwp  [3];
  logic [DW-1:0] fdout [3];
  logic [2:0]    force_full = 3'b000;
  int            viol = 0;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      fifo_full_i[k]  = (fcnt[k] >= DEPTH) || force_full[k];
      fifo_empty_i[k] = (fcnt[k] == 0);
    end
  end
  assign fifo_data_out_i = {fdout[2], fdout[1], fdout[0]};

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 3; k++) begin
        fcnt[k] <= 0; frp[k] <= 0; fwp[k] <= 0; fdout[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin : g_upd
        int c;
        c = fcnt[k];
        if (fifo_rd_en_o[k]) begin
          if (fcnt[k] == 0) viol++;
          else begin
            fdout[k] <= fmem[k][frp[k]];
            frp[k]   <= (frp[k] + 1) % DEPTH;
            c--;
          end
        end
        if (fifo_wr_en_o[k]) begin
          if (fcnt[k] >= DEPTH) viol++;
          else begin
            fmem[k][fwp[k]] <= fifo_data_in_o[k*DW +: DW];
            fwp[k]          <= (fwp[k] + 1) % DEPTH;
            c++;
          end
        end
        fcnt[k] <= c;
      end
    end
  end

  // ---------------- scoreboard and monitor ----------------
  logic [3*DW-1:0] exp_q[$];
  logic [1:0]      exp_flags[$];
  logic [3*DW-1:0] e_col;
  logic [1:0]      e_fl;
  int              beats = 0;

  always @(negedge clk) begin
    if (rstn && col_valid) begin
      beats++;
      if (exp_q.size() == 0) begin
        chk("col_unexpected", 96'(col_valid), 96'(0));
      end else begin
        e_col = exp_q.pop_front();
        e_fl  = exp_flags.pop_front();
        chk("col_data", col_data, e_col);
`ifdef LBS_EDGE_FLAG_EN
        chk("col_first", 96'(col_first), 96'(e_fl[1]));
        chk("col_last", 96'(col_last), 96'(e_fl[0]));
`endif
      end
    end
  end

  logic [DW-1:0] img [256];

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 96'(busy), 96'(0));
    chk({tag, "_done"}, 96'(done), 96'(0));
    chk({tag, "_cfg_err"}, 96'(cfg_err), 96'(0));
    chk({tag, "_col_valid"}, 96'(col_valid), 96'(0));
    chk({tag, "_in_ready"}, 96'(in_ready), 96'(0));
    chk({tag, "_wr_en"}, 96'(fifo_wr_en_o), 96'(0));
    chk({tag, "_rd_en"}, 96'(fifo_rd_en_o), 96'(0));
    chk({tag, "_col_data"}, col_data, 96'(0));
    chk({tag, "_fifo_din"}, fifo_data_in_o, 96'(0));
  endtask

  // One frame: seq=1 gives pixels 1..N, else random. stall forces fifo1 full
  // for 5 cycles in row 2; restart_at pulses start_op mid-STREAM; abort_at
  // applies rstn mid-frame.
  task automatic run_frame(input int w, input int h, input bit seq, input int vprob,
                           input bit stall, input int restart_at, input int abort_at);
    int n, idx, cyc, stall_left;
    bit stalled, restarted, got;
    logic [2:0] prev_empty;
    n = w * h;
    for (int i = 0; i < n; i++) img[i] = seq ? DW'(i + 1) : DW'($urandom);
    for (int r = 2; r < h; r++)
      for (int c = 0; c < w; c++) begin
        exp_q.push_back({img[(r-2)*w+c], img[(r-1)*w+c], img[r*w+c]});
        exp_flags.push_back({c == 0, c == w - 1});
      end
    beats = 0;
    @(posedge clk); #1;
    start_op = 1'b1; width = DIMW'(w); height = DIMW'(h);
    @(posedge clk); #1;
    start_op = 1'b0;
    idx = 0; cyc = 0; stall_left = 0; stalled = 0; restarted = 0;
    while (idx < n && cyc < 20 * n + 100) begin
      @(posedge clk); #1;
      start_op = 1'b0; width = DIMW'(w); height = DIMW'(h);
      if (stalled && stall_left == 0) force_full = 3'b000;
      if (abort_at >= 0 && idx == abort_at) begin
        #1 rstn = 1'b0;
        #1 check_quiet("abort");
        exp_q.delete(); exp_flags.delete();
        in_valid = 1'b0; force_full = 3'b000;
        @(posedge clk); #1 rstn = 1'b1;
        return;
      end
      if (stall && !stalled && idx == 2 * w + 2) begin
        force_full = 3'b010; stall_left = 5; stalled = 1;
      end
      if (restart_at >= 0 && !restarted && idx == restart_at) begin
        start_op = 1'b1; width = DIMW'(w + 3); height = DIMW'(2); restarted = 1;
      end
      in_valid = ($urandom_range(99) < vprob);
      in_pixel = img[idx];
      @(negedge clk);
      if (stall_left > 0) begin
        chk("stall_in_ready", 96'(in_ready), 96'(0));
        stall_left--;
      end
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    if (idx < n) chk("feed_timeout", 96'(idx), 96'(n));
    @(posedge clk); #1;
    in_valid = 1'b0; start_op = 1'b0; force_full = 3'b000;
    got = 0; cyc = 0; prev_empty = 3'b000;
    while (!got && cyc < 500) begin
      @(negedge clk);
      if (done) got = 1;
      else prev_empty = fifo_empty_i;
      cyc++;
    end
    chk("done_seen", 96'(got), 96'(1));
    if (got) begin
      chk("cfg_err_at_done", 96'(cfg_err), 96'(0));
      chk("busy_at_done", 96'(busy), 96'(1));
      chk("fifos_empty_at_done", 96'(fifo_empty_i), 96'(3'b111));
      chk("empty_before_done", 96'(prev_empty), 96'(3'b111));
      chk("beat_count", 96'(beats), 96'((h - 2) * w));
      chk("scoreboard_left", 96'(exp_q.size()), 96'(0));
      chk("fifo_protocol", 96'(viol), 96'(0));
      @(negedge clk);
      chk("done_pulse", 96'(done), 96'(0));
      chk("busy_after_done", 96'(busy), 96'(0));
    end
  endtask

  task automatic cfg_err_case(input int w, input int h);
    @(posedge clk); #1;
    start_op = 1'b1; width = DIMW'(w); height = DIMW'(h);
    @(posedge clk); #1;
    start_op = 1'b0;
    @(negedge clk);
    chk("cfgerr_done", 96'(done), 96'(1));
    chk("cfgerr_flag", 96'(cfg_err), 96'(1));
    chk("cfgerr_wr_en", 96'(fifo_wr_en_o), 96'(0));
    chk("cfgerr_rd_en", 96'(fifo_rd_en_o), 96'(0));
    @(negedge clk);
    chk("cfgerr_pulse", 96'({done, cfg_err, busy}), 96'(0));
  endtask

  initial begin
    int rw, rh;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 rstn = 1'b1;

    run_frame(4, 3, 1, 100, 0, -1, -1);      // directed 4x3
    run_frame(3, 5, 1, 100, 0, -1, -1);      // directed 3x5
    run_frame(5, 4, 0, 60, 1, -1, -1);       // random valid + fifo1 stall
    cfg_err_case(4, 2);
    cfg_err_case(0, 5);
    run_frame(4, 4, 0, 80, 0, 9, -1);        // start_op mid-STREAM ignored
    run_frame(5, 4, 0, 90, 0, -1, 12);       // reset mid-STREAM
    run_frame(4, 3, 1, 100, 0, -1, -1);      // clean frame after reset
    for (int f = 0; f < 4; f++) begin
      rw = $urandom_range(12, 1);
      rh = $urandom_range(7, 3);
      run_frame(rw, rh, 0, 70, 0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
